// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int unsigned  XLEN_DEF     = 32;
  localparam logic [31:0]  RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_buf.sv
// Single-entry {valid,pc,instr} holding register between the imem response and regD.
// Priority: flush (redirect) over write (new response) over clear (consume or bubble).
module fetch_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            write_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (write_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the payload is reset as well: it is a single entry and the outputs must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem request at a time,
// buffers one {pc,instr} for regD and drops responses made stale by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_i_regF_stall,
  input  logic            ctrl_i_regF_bubble,
  input  logic            redirect_i_valid,
  input  logic [XLEN-1:0] redirect_i_pc,
  output logic            imem_o_req_valid,
  input  logic            imem_i_req_ready,
  output logic [XLEN-1:0] imem_o_req_addr,
  input  logic            imem_i_resp_valid,
  input  logic [XLEN-1:0] imem_i_resp_data,
  output logic            fetch_o_valid,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic [XLEN-1:0] fetch_o_instr,
  output logic            fetch_o_busy
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;

  logic            buf_valid;
  logic            buf_write;
  logic            consume;
  logic            buf_free;
  logic            req_fire;
  logic [XLEN-1:0] redirect_pc;
  logic            unused_redirect_lsbs;

  assign redirect_pc          = {redirect_i_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_i_pc[1:0];

  // The buffer frees up this cycle if it is empty, read by regD, or discarded by a bubble.
  assign consume  = buf_valid & ~ctrl_i_regF_stall;
  assign buf_free = ~buf_valid | consume | ctrl_i_regF_bubble;

  // rst_n gates the request so the port stays quiet while reset is held.
  assign imem_o_req_valid = rst_n & (state_q == FS_REQ) & buf_free;
  assign imem_o_req_addr  = pc_q;
  assign req_fire         = imem_o_req_valid & imem_i_req_ready;
  assign fetch_o_busy     = (state_q == FS_WAIT);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    drop_d    = drop_q;
    buf_write = 1'b0;

    unique case (state_q)
      FS_REQ: begin
        if (req_fire) begin
          state_d  = FS_WAIT;
          pc_d     = pc_q + XLEN'(4);
          req_pc_d = pc_q;
        end
      end
      FS_WAIT: begin
        if (imem_i_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FS_REQ;
          end else if (buf_free) begin
            // A stalled regD will not drain the new entry next cycle, so park in HOLD.
            buf_write = 1'b1;
            state_d   = ctrl_i_regF_stall ? FS_HOLD : FS_REQ;
          end
        end
      end
      FS_HOLD: begin
        if (buf_free) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase

    // Redirect overrides everything: the PC jumps and any in-flight response becomes stale.
    if (redirect_i_valid) begin
      pc_d      = redirect_pc;
      req_pc_d  = req_pc_q;
      buf_write = 1'b0;
      if ((state_q == FS_WAIT && !imem_i_resp_valid) || req_fire) begin
        drop_d  = 1'b1;
        state_d = FS_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = FS_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  fetch_buf #(.XLEN(XLEN)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i_valid),
    .write_i (buf_write),
    .clear_i (consume | ctrl_i_regF_bubble),
    .pc_i    (req_pc_q),
    .instr_i (imem_i_resp_data),
    .valid_o (buf_valid),
    .pc_o    (fetch_o_pc),
    .instr_o (fetch_o_instr)
  );

  assign fetch_o_valid = buf_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/bubble/redirect/imem timing,
// checked against a stream-level model of the expected request and instruction order.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ctrl_i_regF_stall = 1'b0;
  logic        ctrl_i_regF_bubble = 1'b0;
  logic        redirect_i_valid = 1'b0;
  logic [31:0] redirect_i_pc = '0;
  logic        imem_o_req_valid;
  logic        imem_i_req_ready = 1'b0;
  logic [31:0] imem_o_req_addr;
  logic        imem_i_resp_valid = 1'b0;
  logic [31:0] imem_i_resp_data = '0;
  logic        fetch_o_valid;
  logic [31:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
  logic        fetch_o_busy;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ctrl_i_regF_stall  (ctrl_i_regF_stall),
    .ctrl_i_regF_bubble (ctrl_i_regF_bubble),
    .redirect_i_valid   (redirect_i_valid),
    .redirect_i_pc      (redirect_i_pc),
    .imem_o_req_valid   (imem_o_req_valid),
    .imem_i_req_ready   (imem_i_req_ready),
    .imem_o_req_addr    (imem_o_req_addr),
    .imem_i_resp_valid  (imem_i_resp_valid),
    .imem_i_resp_data   (imem_i_resp_data),
    .fetch_o_valid      (fetch_o_valid),
    .fetch_o_pc         (fetch_o_pc),
    .fetch_o_instr      (fetch_o_instr),
    .fetch_o_busy       (fetch_o_busy)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus knobs (directed) or randomised each cycle when rand_mode is set.
  bit          rand_mode = 0;
  bit          k_stall = 0, k_bubble = 0, k_redir = 0, k_ready = 0;
  logic [31:0] k_redir_pc = '0;
  int          k_delay = 0;

  // Reference model: imem with one pending request, plus expected request/output PC streams.
  bit          pend = 0, stale = 0;
  logic [31:0] pend_addr = '0;
  int          delay = 0;
  logic [31:0] req_exp = RST_PC;
  logic [31:0] out_exp = RST_PC;
  int          nconsumed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RST_PC;
    return {off[15:0], 16'h0013};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend    = 0;
    stale   = 0;
    delay   = 0;
    req_exp = RST_PC;
    out_exp = RST_PC;
  endtask

  task automatic drive();
    if (rand_mode) begin
      k_stall    = ($urandom_range(0, 3) == 0);
      k_bubble   = ($urandom_range(0, 19) == 0);
      k_redir    = ($urandom_range(0, 24) == 0);
      k_redir_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : (RST_PC + 32'($urandom_range(0, 1023)));
      k_ready    = ($urandom_range(0, 9) < 7);
      k_delay    = $urandom_range(0, 3);
    end
    ctrl_i_regF_stall  = k_stall;
    ctrl_i_regF_bubble = k_bubble;
    redirect_i_valid   = k_redir;
    redirect_i_pc      = k_redir_pc;
    imem_i_req_ready   = k_ready;
    if (pend && delay == 0) begin
      imem_i_resp_valid = 1'b1;
      imem_i_resp_data  = mem_word(pend_addr);
    end else begin
      imem_i_resp_valid = 1'b0;
      imem_i_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  // Judge the cycle just driven against the model, then advance the model past the coming edge.
  task automatic evaluate();
    bit hs, acc;
    hs  = imem_o_req_valid & imem_i_req_ready;
    acc = imem_i_resp_valid & (k_redir | stale | !fetch_o_valid | !k_stall | k_bubble);
    check("busy", 32'(fetch_o_busy), 32'(pend));
    check("single_outstanding", 32'(imem_o_req_valid & pend), 32'd0);
    if (fetch_o_valid && !k_redir) begin
      check("out_pc", fetch_o_pc, out_exp);
      if (!k_bubble && !k_stall) begin
        check("out_instr", fetch_o_instr, mem_word(out_exp));
        nconsumed++;
        out_exp += 32'd4;
      end else if (k_bubble) begin
        out_exp += 32'd4;
      end
    end
    if (acc) pend = 0;
    else if (pend && delay > 0) delay--;
    if (hs) begin
      if (!k_redir) begin
        check("req_addr", imem_o_req_addr, req_exp);
        req_exp += 32'd4;
      end
      pend      = 1;
      stale     = k_redir;
      pend_addr = imem_o_req_addr;
      delay     = k_delay;
    end
    if (k_redir) begin
      if (pend) stale = 1;
      req_exp = {k_redir_pc[31:2], 2'b00};
      out_exp = {k_redir_pc[31:2], 2'b00};
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    evaluate();
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    rand_mode = 0;
    k_stall   = 0; k_bubble = 0; k_redir = 0; k_ready = 0; k_delay = 0;
    model_reset();
    drive();
    #1;
    check("rst_req_valid", 32'(imem_o_req_valid), 32'd0);
    check("rst_req_addr", imem_o_req_addr, RST_PC);
    check("rst_out_valid", 32'(fetch_o_valid), 32'd0);
    check("rst_out_pc", fetch_o_pc, 32'd0);
    check("rst_out_instr", fetch_o_instr, 32'd0);
    check("rst_busy", 32'(fetch_o_busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    apply_reset();

    // Back-to-back fetch from reset.
    k_ready = 1;
    cycle();
    check("t1_req_valid0", 32'(imem_o_req_valid), 32'd1);
    check("t1_req_addr0", imem_o_req_addr, 32'h8000_0000);
    check("t1_out_valid0", 32'(fetch_o_valid), 32'd0);
    cycle();
    check("t1_req_valid1", 32'(imem_o_req_valid), 32'd0);
    cycle();
    check("t1_out_valid2", 32'(fetch_o_valid), 32'd1);
    check("t1_out_pc2", fetch_o_pc, 32'h8000_0000);
    check("t1_out_instr2", fetch_o_instr, 32'h0000_0013);
    check("t1_req_addr2", imem_o_req_addr, 32'h8000_0004);
    check("t1_req_valid2", 32'(imem_o_req_valid), 32'd1);
    cycle();

    // Load-use stall with a full buffer.
    k_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_out_valid", 32'(fetch_o_valid), 32'd1);
      check("t2_out_pc", fetch_o_pc, 32'h8000_0004);
      check("t2_out_instr", fetch_o_instr, 32'h0004_0013);
      check("t2_req_valid", 32'(imem_o_req_valid), 32'd0);
      check("t2_req_addr", imem_o_req_addr, 32'h8000_0008);
    end
    k_stall = 0;
    k_delay = 1;
    cycle();
    check("t2_req_resume", imem_o_req_addr, 32'h8000_0008);

    // Redirect while waiting; the late response must be dropped.
    k_delay    = 0;
    k_redir    = 1;
    k_redir_pc = 32'h8000_0102;
    cycle();
    check("t3_busy_redirect", 32'(fetch_o_busy), 32'd1);
    k_redir = 0;
    cycle();
    check("t3_stale_resp", 32'(imem_i_resp_valid), 32'd1);
    check("t3_out_dropped", 32'(fetch_o_valid), 32'd0);
    cycle();
    check("t3_out_still_empty", 32'(fetch_o_valid), 32'd0);
    check("t3_req_addr", imem_o_req_addr, 32'h8000_0100);
    check("t3_req_valid", 32'(imem_o_req_valid), 32'd1);
    cycle();

    // Bubble discards a full buffer; next output is the following PC.
    k_bubble = 1;
    cycle();
    check("t4_out_pc_before", fetch_o_pc, 32'h8000_0100);
    check("t4_out_instr_before", fetch_o_instr, 32'h0100_0013);
    check("t4_req_addr", imem_o_req_addr, 32'h8000_0104);
    k_bubble = 0;
    cycle();
    check("t4_out_cleared", 32'(fetch_o_valid), 32'd0);
    check("t4_pc_unchanged", imem_o_req_addr, 32'h8000_0108);

    // imem backpressure for four cycles.
    k_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 0) check("t4_next_pc", fetch_o_pc, 32'h8000_0104);
      check("t5_req_valid_held", 32'(imem_o_req_valid), 32'd1);
      check("t5_req_addr_held", imem_o_req_addr, 32'h8000_0108);
    end
    k_ready = 1;
    cycle();
    check("t5_req_accept", imem_o_req_addr, 32'h8000_0108);
    cycle();
    check("t5_busy_after", 32'(fetch_o_busy), 32'd1);

    // Asynchronous reset while a request is outstanding.
    #2;
    apply_reset();
    k_ready = 1;
    cycle();
    check("t6_req_valid", 32'(imem_o_req_valid), 32'd1);
    check("t6_req_addr", imem_o_req_addr, 32'h8000_0000);

    // Random traffic against the stream model.
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) cycle();
    rand_mode = 0;
    check("progress", 32'(nconsumed > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
